// File: rtl/sprite_line_engine.sv
// sprite_line_engine -- per-scanline sprite compositor.
//
// Holds NUM_SLOTS sprite slots loaded through a valid/ready handshake. Each
// enable advances one pixel: a slot counts its X down to zero, then shifts
// out 8 pixels of BPP bitplanes, then stays transparent until the next line
// start. The lowest-index opaque slot wins the registered composite output.
//
// Ports:
//   clk, i_rst_n (async, active low), i_ce (clock enable)
//   i_line_start                    empty all slots, clear overflow
//   i_load_valid / o_load_ready     slot-load handshake
//   i_load_x/pat/pal/prio/hflip/is0 slot contents (pat plane p = [8p+7:8p])
//   i_enable                        advance one pixel
//   o_pix/o_pal/o_prio/o_hit0       composited pixel, 1-cycle latency
//   o_overflow                      load offered while full (sticky per line)
//   o_count                         occupied slot count

module sprite_slot #(
    parameter int BPP = 2,
    parameter int XW  = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [XW-1:0]    i_x,
    input  logic [8*BPP-1:0] i_pat,
    input  logic [1:0]       i_pal,
    input  logic             i_prio,
    input  logic             i_hflip,
    input  logic             i_is0,
    output logic             o_occ,
    output logic [BPP-1:0]   o_pix,
    output logic [1:0]       o_pal,
    output logic             o_prio,
    output logic             o_is0
);
    logic                  r_occ;
    logic [XW-1:0]         r_cnt;
    logic [BPP-1:0][7:0]   r_sh;
    logic [1:0]            r_pal;
    logic                  r_prio;
    logic                  r_hflip;
    logic                  r_is0;
    logic [3:0]            r_emit;
    logic                  w_active;

    assign w_active = r_occ && (r_cnt == '0) && (r_emit < 4'd8);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_occ   <= 1'b0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_pal   <= '0;
            r_prio  <= 1'b0;
            r_hflip <= 1'b0;
            r_is0   <= 1'b0;
            r_emit  <= '0;
        end else if (i_ce) begin
            if (i_clear) begin
                r_occ  <= 1'b0;
                r_emit <= '0;
            end else if (i_load) begin
                // a fresh load overrides any advance in the same cycle
                r_occ   <= 1'b1;
                r_cnt   <= i_x;
                r_sh    <= i_pat;
                r_pal   <= i_pal;
                r_prio  <= i_prio;
                r_hflip <= i_hflip;
                r_is0   <= i_is0;
                r_emit  <= '0;
            end else if (i_enable && r_occ) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else if (r_emit < 4'd8) begin
                    for (int p = 0; p < BPP; p++)
                        r_sh[p] <= r_hflip ? {1'b0, r_sh[p][7:1]} : {r_sh[p][6:0], 1'b0};
                    r_emit <= r_emit + 4'd1;
                end
            end
        end
    end

    always_comb begin
        o_pix = '0;
        for (int p = 0; p < BPP; p++)
            o_pix[p] = w_active & (r_hflip ? r_sh[p][0] : r_sh[p][7]);
    end

    assign o_occ  = r_occ;
    assign o_pal  = r_pal;
    assign o_prio = r_prio;
    assign o_is0  = r_is0;
endmodule

module sprite_line_engine #(
    parameter int NUM_SLOTS = 8,
    parameter int BPP       = 2,
    parameter int XW        = 8,
    localparam int CW       = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic             i_line_start,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [XW-1:0]    i_load_x,
    input  logic [8*BPP-1:0] i_load_pat,
    input  logic [1:0]       i_load_pal,
    input  logic             i_load_prio,
    input  logic             i_load_hflip,
    input  logic             i_load_is0,
    input  logic             i_enable,
    output logic [BPP-1:0]   o_pix,
    output logic [1:0]       o_pal,
    output logic             o_prio,
    output logic             o_hit0,
    output logic             o_overflow,
    output logic [CW-1:0]    o_count
);
    logic [NUM_SLOTS-1:0]          w_occ;
    logic [NUM_SLOTS-1:0]          w_load_vec;
    logic [NUM_SLOTS-1:0][BPP-1:0] w_spix;
    logic [NUM_SLOTS-1:0][1:0]     w_spal;
    logic [NUM_SLOTS-1:0]          w_sprio;
    logic [NUM_SLOTS-1:0]          w_sis0;
    logic                          w_fire;
    logic                          w_taken;
    logic [CW-1:0]                 w_count;
    logic [BPP-1:0]                w_cpix;
    logic [1:0]                    w_cpal;
    logic                          w_cprio;
    logic                          w_chit;
    logic [BPP-1:0]                r_pix;
    logic [1:0]                    r_pal;
    logic                          r_prio;
    logic                          r_hit0;
    logic                          r_ovf;

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
            sprite_slot #(.BPP(BPP), .XW(XW)) u_slot (
                .clk      (clk),
                .i_rst_n  (i_rst_n),
                .i_ce     (i_ce),
                .i_clear  (i_line_start),
                .i_load   (w_load_vec[g]),
                .i_enable (i_enable),
                .i_x      (i_load_x),
                .i_pat    (i_load_pat),
                .i_pal    (i_load_pal),
                .i_prio   (i_load_prio),
                .i_hflip  (i_load_hflip),
                .i_is0    (i_load_is0),
                .o_occ    (w_occ[g]),
                .o_pix    (w_spix[g]),
                .o_pal    (w_spal[g]),
                .o_prio   (w_sprio[g]),
                .o_is0    (w_sis0[g])
            );
        end
    endgenerate

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            w_count = w_count + CW'(w_occ[i]);
    end

    assign o_load_ready = (w_count < CW'(NUM_SLOTS)) && !i_line_start;
    assign w_fire       = i_ce && i_load_valid && o_load_ready;

    // one-hot select of the lowest-index empty slot
    always_comb begin
        w_load_vec = '0;
        w_taken    = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_occ[i] && !w_taken) begin
                w_load_vec[i] = w_fire;
                w_taken       = 1'b1;
            end
        end
    end

    // walk high to low so the lowest opaque index wins; pal/prio fall back
    // to slot 0's registers when nothing is opaque
    always_comb begin
        w_cpix  = '0;
        w_cpal  = w_spal[0];
        w_cprio = w_sprio[0];
        w_chit  = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (|w_spix[i]) begin
                w_cpix  = w_spix[i];
                w_cpal  = w_spal[i];
                w_cprio = w_sprio[i];
                w_chit  = w_chit | w_sis0[i];
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix  <= '0;
            r_pal  <= '0;
            r_prio <= 1'b0;
            r_hit0 <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (i_ce) begin
            if (i_enable) begin
                r_pix  <= w_cpix;
                r_pal  <= w_cpal;
                r_prio <= w_cprio;
                r_hit0 <= w_chit;
            end
            if (i_line_start)
                r_ovf <= 1'b0;
            else if (i_load_valid && !o_load_ready)
                r_ovf <= 1'b1;
        end
    end

    assign o_pix      = r_pix;
    assign o_pal      = r_pal;
    assign o_prio     = r_prio;
    assign o_hit0     = r_hit0;
    assign o_overflow = r_ovf;
    assign o_count    = w_count;
endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench for sprite_line_engine: directed scenarios followed by
// randomized traffic, all compared against a slot-timeline reference model.
module tb_sprite_line_engine;
    localparam int N   = 8;
    localparam int BPP = 2;
    localparam int XW  = 8;
    localparam int CW  = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             rst_n, ce, line_start, load_valid, enable;
    logic [XW-1:0]    load_x;
    logic [8*BPP-1:0] load_pat;
    logic [1:0]       load_pal;
    logic             load_prio, load_hflip, load_is0;
    logic             load_ready;
    logic [BPP-1:0]   pix;
    logic [1:0]       pal;
    logic             prio, hit0, ovf;
    logic [CW-1:0]    count;

    sprite_line_engine #(.NUM_SLOTS(N), .BPP(BPP), .XW(XW)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_line_start(line_start),
        .i_load_valid(load_valid), .o_load_ready(load_ready),
        .i_load_x(load_x), .i_load_pat(load_pat), .i_load_pal(load_pal),
        .i_load_prio(load_prio), .i_load_hflip(load_hflip), .i_load_is0(load_is0),
        .i_enable(enable), .o_pix(pix), .o_pal(pal), .o_prio(prio),
        .o_hit0(hit0), .o_overflow(ovf), .o_count(count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each slot is a timeline. t counts enables since load;
    // the slot shows seq[t-x] for x <= t < x+8 and is transparent otherwise.
    bit       m_occ [N];
    int       m_x   [N];
    int       m_t   [N];
    int       m_seq [N][8];
    int       m_pal [N];
    int       m_prio[N];
    bit       m_is0 [N];
    bit       m_ovf;
    int       e_pix, e_pal, e_prio, e_hit;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_occ[i]);
        return c;
    endfunction

    function automatic int m_pixel(int i);
        int k;
        if (!m_occ[i]) return 0;
        k = m_t[i] - m_x[i];
        if (k >= 0 && k < 8) return m_seq[i][k];
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_occ[i] = 0; m_x[i] = 0; m_t[i] = 0; m_pal[i] = 0;
            m_prio[i] = 0; m_is0[i] = 0;
            for (int k = 0; k < 8; k++) m_seq[i][k] = 0;
        end
        m_ovf = 0; e_pix = 0; e_pal = 0; e_prio = 0; e_hit = 0;
    endtask

    task automatic m_edge();
        int v, s;
        if (!ce) return;
        if (enable) begin
            e_pix = 0; e_pal = m_pal[0]; e_prio = m_prio[0]; e_hit = 0;
            for (int i = 0; i < N; i++) begin
                v = m_pixel(i);
                if (v != 0) begin
                    if (e_pix == 0) begin
                        e_pix = v; e_pal = m_pal[i]; e_prio = m_prio[i];
                    end
                    if (m_is0[i]) e_hit = 1;
                end
            end
            for (int i = 0; i < N; i++) if (m_occ[i]) m_t[i]++;
        end
        if (line_start) begin
            for (int i = 0; i < N; i++) m_occ[i] = 0;
            m_ovf = 0;
        end else if (load_valid) begin
            if (m_count() < N) begin
                s = 0;
                while (m_occ[s]) s++;
                m_occ[s] = 1; m_x[s] = int'(load_x); m_t[s] = 0;
                m_pal[s] = int'(load_pal); m_prio[s] = int'(load_prio);
                m_is0[s] = load_is0;
                for (int k = 0; k < 8; k++) begin
                    v = 0;
                    for (int p = 0; p < BPP; p++)
                        if (load_pat[8*p + (load_hflip ? k : 7 - k)]) v += (1 << p);
                    m_seq[s][k] = v;
                end
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // One clock: check the combinational ready, step the model, then check
    // the registered outputs just after the edge.
    task automatic tick();
        #1;
        chk("ready", int'(load_ready), int'(m_count() < N && !line_start));
        m_edge();
        @(posedge clk);
        #1;
        chk("pix",   int'(pix),   e_pix);
        chk("pal",   int'(pal),   e_pal);
        chk("prio",  int'(prio),  e_prio);
        chk("hit0",  int'(hit0),  e_hit);
        chk("ovf",   int'(ovf),   int'(m_ovf));
        chk("count", int'(count), m_count());
    endtask

    task automatic idle();
        ce = 1; line_start = 0; load_valid = 0; enable = 0;
    endtask

    task automatic do_load(input int x, input int pat, input int pl, input bit pr,
                           input bit hf, input bit z);
        load_x = XW'(x); load_pat = (8*BPP)'(pat); load_pal = 2'(pl);
        load_prio = pr; load_hflip = hf; load_is0 = z;
        load_valid = 1; tick(); load_valid = 0;
    endtask

    task automatic new_line();
        line_start = 1; tick(); line_start = 0;
    endtask

    int exp30[12] = '{0,0,0,1,0,0,0,0,0,0,1,0};
    int exp31[8]  = '{1,1,0,0,0,0,0,0};

    initial begin
        rst_n = 0; idle();
        load_x = '0; load_pat = '0; load_pal = '0;
        load_prio = 0; load_hflip = 0; load_is0 = 0;
        m_reset();
        #12;
        chk("rst_pix", int'(pix), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_ready", int'(load_ready), 1);
        @(negedge clk); rst_n = 1;
        tick();

        // single sprite, X=3, plane0 = 1000_0001, no flip
        do_load(3, 16'h0081, 1, 0, 0, 0);
        enable = 1;
        for (int i = 0; i < 12; i++) begin tick(); chk("seq30", int'(pix), exp30[i]); end
        for (int i = 0; i < 4; i++) begin tick(); chk("done30", int'(pix), 0); end
        enable = 0;

        // same placement, flipped, pattern 0000_0011
        new_line();
        do_load(3, 16'h0003, 0, 0, 1, 0);
        enable = 1;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 8; i++) begin tick(); chk("seq31", int'(pix), exp31[i]); end
        enable = 0;

        // two overlapping sprites at X=0, lower index wins while opaque
        new_line();
        do_load(0, 16'h00F0, 0, 0, 0, 0);
        do_load(0, 16'hFFFF, 2, 1, 0, 0);
        enable = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("pix32", int'(pix), (i < 4) ? 1 : 3);
            if (i >= 4) chk("pal32", int'(pal), 2);
        end
        enable = 0;

        // overflow: 9 back-to-back loads
        new_line();
        for (int i = 0; i < 9; i++) do_load(i, $urandom, 0, 0, 0, 0);
        chk("cnt33", int'(count), 8);
        chk("rdy33", int'(load_ready), 0);
        chk("ovf33", int'(ovf), 1);
        new_line();
        chk("cnt33b", int'(count), 0);
        chk("ovf33b", int'(ovf), 0);

        // line start beats a same-cycle load
        line_start = 1; do_load(0, 16'hFFFF, 1, 0, 0, 0); line_start = 0;
        chk("cnt34", int'(count), 0);
        do_load(0, 16'h0080, 0, 0, 0, 1);
        enable = 1;
        for (int i = 0; i < 3; i++) begin tick(); chk("hit34", int'(hit0), (i == 0) ? 1 : 0); end
        enable = 0;

        // async reset mid-emission
        new_line();
        do_load(0, 16'hFFFF, 3, 1, 0, 0);
        enable = 1; tick(); tick(); enable = 0;
        #2; rst_n = 0; #1;
        chk("ar_pix", int'(pix), 0);
        chk("ar_pal", int'(pal), 0);
        chk("ar_prio", int'(prio), 0);
        chk("ar_cnt", int'(count), 0);
        m_reset();
        #1; rst_n = 1;
        tick();

        // randomized traffic
        for (int it = 0; it < 2000; it++) begin
            ce         = ($urandom % 8) != 0;
            enable     = $urandom % 2;
            line_start = ($urandom % 50) == 0;
            load_valid = ($urandom % 4) == 0;
            load_x     = XW'($urandom % 12);
            load_pat   = (8*BPP)'($urandom);
            load_pal   = 2'($urandom);
            load_prio  = $urandom % 2;
            load_hflip = $urandom % 2;
            load_is0   = ($urandom % 4) == 0;
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_line_engine.md
SPRITE_LINE_ENGINE -- requirements
Module: sprite_line_engine

Interface
REQ-001 The module SHALL have parameter NUM_SLOTS, default 8, giving the number of sprite slots (2..16).
REQ-002 The module SHALL have parameter BPP, default 2, giving bitplanes per pixel (1..4).
REQ-003 The module SHALL have parameter XW, default 8, giving the X coordinate width.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The module SHALL have port i_rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-006 The module SHALL have port i_ce, input, 1 bit, clock enable; all state other than reset holds when low.
REQ-007 The module SHALL have port i_line_start, input, 1 bit, which empties all slots and clears the line flags.
REQ-008 The module SHALL have ports i_load_valid (input, 1 bit) and o_load_ready (output, 1 bit), the slot-load handshake.
REQ-009 The module SHALL have ports i_load_x (input, XW), i_load_pat (input, 8*BPP; plane p in bits [8p+7:8p]), i_load_pal (input, 2), i_load_prio (input, 1), i_load_hflip (input, 1) and i_load_is0 (input, 1), the slot contents.
REQ-010 The module SHALL have port i_enable, input, 1 bit, which advances one pixel.
REQ-011 The module SHALL have outputs o_pix (BPP), o_pal (2), o_prio (1) and o_hit0 (1), the composited pixel.
REQ-012 The module SHALL have output o_overflow, 1 bit, sticky per line: a load was offered while all slots were full.
REQ-013 The module SHALL have output o_count, width $clog2(NUM_SLOTS+1), the number of occupied slots.

Function
REQ-014 A load SHALL occur on a cycle with i_ce, i_load_valid and o_load_ready all high; it writes the lowest-index empty slot and marks it occupied.
REQ-015 o_load_ready SHALL equal (o_count < NUM_SLOTS) && !i_line_start.
REQ-016 If i_load_valid && i_ce && !o_load_ready && !i_line_start, the module SHALL set o_overflow; the load SHALL be dropped and no slot changed.
REQ-017 i_line_start SHALL take priority over a same-cycle load: all slots become empty, o_count=0, o_overflow=0, and the load is not accepted.
REQ-018 Each slot SHALL hold an XW-bit down-counter, BPP 8-bit shift registers, pal, prio, hflip, is0, a 4-bit emitted-pixel counter, and an occupied bit.
REQ-019 On i_ce && i_enable, an occupied slot with counter != 0 SHALL decrement the counter.
REQ-020 On i_ce && i_enable, an occupied slot with counter == 0 and fewer than 8 pixels emitted SHALL be active; it SHALL shift right when hflip=1 (head = bit 0) and left when hflip=0 (head = bit 7), then increment the emitted count.
REQ-021 After 8 emitted pixels a slot SHALL be done; it outputs transparent (0) until the next line start, and the counter SHALL NOT wrap.
REQ-022 A slot's pixel SHALL be its BPP head bits when active and 0 otherwise; a pixel is opaque when nonzero.
REQ-023 The composite SHALL select the opaque slot with the lowest index; if none is opaque, o_pix=0 and o_pal/o_prio come from slot 0's register values.
REQ-024 o_hit0 SHALL be high when any opaque slot has is0=1.
REQ-025 The outputs SHALL be registered with 1-cycle latency: on an i_ce && i_enable edge they capture the composite of pre-shift state; on cycles without enable they hold.
REQ-026 A slot loaded on the same cycle as i_enable SHALL take the loaded values; it does not advance that cycle.
REQ-027 Loaded X=0 SHALL make the slot active on the very next enable cycle.

Reset
REQ-028 While i_rst_n=0 (asynchronously), all slots SHALL be empty, all slot registers 0, and o_pix=0, o_pal=0, o_prio=0, o_hit0=0, o_overflow=0, o_count=0.
REQ-029 o_load_ready SHALL be 1 after reset release; reset asserted mid-line SHALL abort all slot activity immediately.

Verification
REQ-030 Bench: load X=3, pat=8'b1000_0001/8'h00, hflip=0, then 12 enables -> o_pix sequence 0,0,0,1,0,0,0,0,0,0,1,0 (1-cycle latency applied), then 0 thereafter.
REQ-031 Bench: same slot with hflip=1, pat=8'b0000_0011 -> first two active pixels are 1, the remaining six are 0.
REQ-032 Bench: slot0 and slot1 both at X=0, slot0 pat 8'hF0/8'h00, slot1 pat 8'hFF/8'hFF with pal=2 -> first 4 pixels o_pix=1 from slot0, next 4 o_pix=3 with o_pal=2.
REQ-033 Bench: 9 back-to-back loads with NUM_SLOTS=8 -> o_count=8, o_load_ready=0, o_overflow=1 after the 9th; i_line_start -> o_count=0, o_overflow=0.
REQ-034 Bench: i_line_start and i_load_valid in the same cycle -> o_count=0 and no load accepted; i_load_is0=1 with an opaque pixel -> o_hit0=1 for exactly that pixel.
REQ-035 Bench: assert i_rst_n=0 mid-emission, asynchronously to clk -> all outputs are 0 before the next edge.
